// File: rtl/ram_responder_pkg.sv
// Shared widths and FSM encoding for the burst memory responder.
package ram_responder_pkg;

  localparam int unsigned RamAddrWidth = 32;
  localparam int unsigned RamLenWidth  = 8;
  localparam int unsigned RamDataWidth = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRead  = 2'd2
  } state_e;

endpackage

// File: rtl/ram_responder_array.sv
// Single-port synchronous word memory with a registered, enable-gated read port.
module ram_array #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DWIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     re_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DWIDTH-1:0]        wdata_i,
  output logic [DWIDTH-1:0]        rdata_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register only loads on re_i so a stalled beat holds its data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Burst memory responder: services one AW+W or AR+R burst at a time from ram_array.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AWIDTH = RamAddrWidth,
  parameter int unsigned LWIDTH = RamLenWidth,
  parameter int unsigned DWIDTH = RamDataWidth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] awaddr,
  input  logic [LWIDTH-1:0] awlen,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DWIDTH-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  output logic              wlast,
  input  logic [AWIDTH-1:0] araddr,
  input  logic [LWIDTH-1:0] arlen,
  input  logic              arvalid,
  output logic              arready,
  output logic [DWIDTH-1:0] rdata,
  output logic              rvalid,
  input  logic              rready,
  output logic              rlast
);

  localparam int unsigned IW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [LWIDTH-1:0] len_q, len_d;
  logic [LWIDTH-1:0] beat_q, beat_d;
  logic [IW-1:0]     ram_addr;
  logic              ram_we;
  logic              ram_re;
  logic              last_beat;

  // Only the word-index slice of each address is significant.
  logic unused_addr;
  assign unused_addr = ^{awaddr, araddr};

  assign last_beat = (beat_q == len_q);

  // Gating with rst keeps both ready lines low while reset is held.
  assign awready = (state_q == StIdle) & rst;
  assign arready = awready & ~awvalid;
  assign wvalid  = (state_q == StWrite);
  assign wlast   = wvalid & last_beat;
  assign rvalid  = (state_q == StRead);
  assign rlast   = rvalid & last_beat;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    beat_d   = beat_q;
    ram_addr = idx_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    case (state_q)
      StIdle: begin
        if (awvalid && awready) begin
          idx_d   = awaddr[2 +: IW];
          len_d   = awlen;
          beat_d  = '0;
          state_d = StWrite;
        end else if (arvalid && arready) begin
          idx_d    = araddr[2 +: IW];
          len_d    = arlen;
          beat_d   = '0;
          ram_addr = araddr[2 +: IW];
          ram_re   = 1'b1;
          state_d  = StRead;
        end
      end
      StWrite: begin
        if (wready) begin
          ram_we = 1'b1;
          idx_d  = idx_q + 1'b1;
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d = StIdle;
          end
        end
      end
      StRead: begin
        if (rready) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            // Prefetch the next word so it is on rdata one cycle later.
            idx_d    = idx_q + 1'b1;
            ram_addr = idx_q + 1'b1;
            ram_re   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  ram_array #(
    .DEPTH (DEPTH),
    .DWIDTH(DWIDTH)
  ) u_ram_array (
    .clk_i  (clk),
    .rst_ni (rst),
    .re_i   (ram_re),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(wdata),
    .rdata_o(rdata)
  );

endmodule

// File: tb/tb_ram_responder.sv
// Randomized self-checking bench for ram_responder against a word-array reference model.
module tb_ram_responder;
  import ram_responder_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = RamAddrWidth;
  localparam int unsigned LW    = RamLenWidth;
  localparam int unsigned DW    = RamDataWidth;

  logic          clk;
  logic          rst;
  logic [AW-1:0] awaddr;
  logic [LW-1:0] awlen;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic          wvalid;
  logic          wready;
  logic          wlast;
  logic [AW-1:0] araddr;
  logic [LW-1:0] arlen;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready;
  logic          rlast;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [DW-1:0] mdl_mem [DEPTH];
  bit            known   [DEPTH];

  ram_responder #(
    .DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .awaddr (awaddr),
    .awlen  (awlen),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wvalid (wvalid),
    .wready (wready),
    .wlast  (wlast),
    .araddr (araddr),
    .arlen  (arlen),
    .arvalid(arvalid),
    .arready(arready),
    .rdata  (rdata),
    .rvalid (rvalid),
    .rready (rready),
    .rlast  (rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned word_of(input logic [AW-1:0] addr);
    return 32'(addr >> 2) % DEPTH;
  endfunction

  task automatic check_reset_outputs();
    check_eq("rst_awready", 32'(awready), 0);
    check_eq("rst_arready", 32'(arready), 0);
    check_eq("rst_wvalid", 32'(wvalid), 0);
    check_eq("rst_wlast", 32'(wlast), 0);
    check_eq("rst_rvalid", 32'(rvalid), 0);
    check_eq("rst_rlast", 32'(rlast), 0);
    check_eq("rst_rdata", rdata, 0);
  endtask

  // Called at posedge+1; spends one cycle checking that the responder is idle.
  task automatic idle_tail();
    @(negedge clk);
    check_eq("tail_wvalid", 32'(wvalid), 0);
    check_eq("tail_rvalid", 32'(rvalid), 0);
    check_eq("tail_awready", 32'(awready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic aw_req(input logic [AW-1:0] addr, input int unsigned len,
                        output int unsigned waited);
    bit got = 1'b0;
    awaddr  = addr;
    awlen   = LW'(len);
    awvalid = 1'b1;
    waited  = 0;
    while (!got && waited < 16) begin
      @(negedge clk);
      if (awready) begin
        got = 1'b1;
        check_eq("ar_yields", 32'(arready), 0);
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    awvalid = 1'b0;
    check_eq("aw_accept", 32'(got), 1);
  endtask

  task automatic ar_req(input logic [AW-1:0] addr, input int unsigned len,
                        output int unsigned waited);
    bit got = 1'b0;
    araddr  = addr;
    arlen   = LW'(len);
    arvalid = 1'b1;
    waited  = 0;
    while (!got && waited < 16) begin
      @(negedge clk);
      if (arready) got = 1'b1;
      else waited++;
      @(posedge clk);
      #1;
    end
    arvalid = 1'b0;
    check_eq("ar_accept", 32'(got), 1);
  endtask

  task automatic w_beats(input int unsigned idx0, input int unsigned len, input bit stall,
                         input bit rnd, input logic [31:0] base);
    int unsigned idx   = idx0;
    int unsigned b     = 0;
    int unsigned guard = 0;
    while (b <= len && guard < 8 * (len + 1) + 16) begin
      wdata  = rnd ? $urandom : base + b;
      wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      check_eq("wvalid", 32'(wvalid), 1);
      check_eq("wlast", 32'(wlast), 32'(b == len));
      check_eq("w_no_req", 32'({awready, arready}), 0);
      if (wready) begin
        mdl_mem[idx] = wdata;
        known[idx]   = 1'b1;
        idx          = (idx + 1) % DEPTH;
        b++;
      end
      @(posedge clk);
      #1;
      wready = 1'b0;
      guard++;
    end
    check_eq("w_beats", b, len + 1);
  endtask

  // mode 0: rready always 1; 1: random; 2: repeating 1,0,0,1 pattern.
  task automatic r_beats(input int unsigned idx0, input int unsigned len, input int mode);
    int unsigned idx   = idx0;
    int unsigned b     = 0;
    int unsigned guard = 0;
    while (b <= len && guard < 8 * (len + 1) + 16) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = 1'($urandom_range(0, 1));
        default: rready = (guard % 4 == 0) || (guard % 4 == 3);
      endcase
      @(negedge clk);
      check_eq("rvalid", 32'(rvalid), 1);
      check_eq("rlast", 32'(rlast), 32'(b == len));
      if (known[idx]) check_eq("rdata", rdata, mdl_mem[idx]);
      if (rready) begin
        idx = (idx + 1) % DEPTH;
        b++;
      end
      @(posedge clk);
      #1;
      rready = 1'b0;
      guard++;
    end
    check_eq("r_beats", b, len + 1);
  endtask

  initial begin
    int unsigned   w;
    int unsigned   len;
    int unsigned   idx;
    logic [AW-1:0] addr;

    rst     = 1'b1;
    awaddr  = '0;
    awlen   = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wready  = 1'b0;
    araddr  = '0;
    arlen   = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    #2 rst = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    #1;
    check_eq("rel_awready", 32'(awready), 1);
    check_eq("rel_arready", 32'(arready), 1);
    awvalid = 1'b1;
    #1;
    check_eq("arready_follows_aw", 32'(arready), 0);
    awvalid = 1'b0;
    @(posedge clk);
    #1;

    // Directed write 0xA0..0xA3 then read back.
    aw_req(32'h10, 3, w);
    check_eq("aw_wait", w, 0);
    w_beats(word_of(32'h10), 3, 1'b0, 1'b0, 32'hA0);
    idle_tail();
    ar_req(32'h10, 3, w);
    r_beats(word_of(32'h10), 3, 0);
    idle_tail();

    // Read with backpressure.
    ar_req(32'h10, 3, w);
    r_beats(word_of(32'h10), 3, 2);
    idle_tail();

    // Simultaneous requests: write first, read on the next idle cycle.
    araddr  = 32'h10;
    arlen   = LW'(3);
    arvalid = 1'b1;
    aw_req(32'h80, 2, w);
    w_beats(word_of(32'h80), 2, 1'b0, 1'b1, 32'h0);
    ar_req(32'h10, 3, w);
    check_eq("ar_after_w", w, 0);
    r_beats(word_of(32'h10), 3, 0);

    // Index wrap at the top of memory.
    aw_req(32'hFFC, 1, w);
    w_beats(DEPTH - 1, 1, 1'b0, 1'b0, 32'hC0DE0000);
    ar_req(32'h000, 0, w);
    r_beats(0, 0, 0);
    ar_req(32'hFFC, 1, w);
    r_beats(DEPTH - 1, 1, 1);

    // All-ones length: 2^LWIDTH beats, wrapping.
    aw_req(AW'(900 * 4), (1 << LW) - 1, w);
    w_beats(900, (1 << LW) - 1, 1'b1, 1'b1, 32'h0);
    ar_req(AW'(900 * 4), (1 << LW) - 1, w);
    r_beats(900, (1 << LW) - 1, 0);
    idle_tail();

    // Reset after beat 1 of a 4-beat write.
    aw_req(32'h40, 3, w);
    w_beats(word_of(32'h40), 3, 1'b0, 1'b0, 32'h11);
    aw_req(32'h40, 3, w);
    for (int k = 0; k < 2; k++) begin
      wdata  = 32'hDEAD0000 + 32'(k);
      wready = 1'b1;
      @(posedge clk);
      #1;
      mdl_mem[word_of(32'h40) + k] = 32'hDEAD0000 + 32'(k);
    end
    wdata = 32'hBAD0BAD0;
    rst   = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    wready = 1'b0;
    rst    = 1'b1;
    #1;
    check_eq("post_rst_idle", 32'(awready), 1);
    @(posedge clk);
    #1;
    ar_req(32'h40, 3, w);
    r_beats(word_of(32'h40), 3, 0);

    // Randomized back-to-back bursts with random wready/rready.
    for (int it = 0; it < 40; it++) begin
      len  = $urandom_range(0, 7);
      idx  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 31) : $urandom_range(1016, 1023);
      addr = ($urandom & 32'hFFFF_F003) | AW'(idx << 2);
      if ($urandom_range(0, 1) != 0) begin
        aw_req(addr, len, w);
        check_eq("turnaround_w", w, 0);
        w_beats(word_of(addr), len, 1'b1, 1'b1, 32'h0);
      end else begin
        ar_req(addr, len, w);
        check_eq("turnaround_r", w, 0);
        r_beats(word_of(addr), len, 1);
      end
    end
    idle_tail();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
